mux4_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of a 4:1 single-bit multiplexer. It drives the mux's 2-bit `sel` round-robin over channels 0..3, holding each channel for a programmable dwell time. It samples the mux output at the end of each dwell and publishes the four captured bits as one 4-bit word per sweep. Sweeps run either once per `start` or continuously until `stop`.

---
 rtl/mux4_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_mux4_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: round-robin select sequencer for a 4:1 single-bit mux.
// Holds each channel for dwell+1 cycles, captures the mux output on the last
// cycle of each dwell and publishes the four captured bits once per sweep.
//
// Handshake: there is no backpressure. A sweep request is accepted on any
// edge where start=1 while busy=0; done is a one-cycle strobe that marks the
// cycle in which sample carries a freshly completed sweep.
module mux4_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [3:0]         sample
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = 1;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         shadow_q, shadow_d;
  logic [1:0]         sel_q, sel_d;
  logic               done_q, done_d;
  logic [3:0]         sample_q, sample_d;

  // Next-state logic: launch on start, count dwell, capture at the end of each dwell.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    cont_d   = cont_q;
    stop_d   = stop_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    sample_d = sample_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dwell_d = dwell;
          cont_d  = cont;
          stop_d  = 1'b0;
          cnt_d   = '0;
          sel_d   = 2'd0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          // Capture edge: the mux output for the current channel is final now.
          cnt_d = '0;
          sel_d = sel_q + 2'd1;
          for (int k = 0; k < 3; k++) begin
            if (sel_q == 2'(k)) begin
              shadow_d[k] = mux_out;
            end
          end
          if (sel_q == 2'd3) begin
            // Whole word is published at once; channel 3 goes straight in.
            sample_d = {mux_out, shadow_q};
            done_d   = 1'b1;
            // A stop arriving on this very edge also ends continuous mode.
            if (!(cont_q && !stop_q && !stop)) begin
              state_d = IDLE;
              stop_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel_q    <= 2'd0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      cont_q   <= cont_d;
      stop_q   <= stop_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      sample_q <= sample_d;
    end
  end

  assign sel    = sel_q;
  assign busy   = (state_q == SCAN);
  assign done   = done_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: a behavioural sweep-timeline model predicts sel,
// busy and every published word; a negedge monitor compares the DUT to it.
module tb_mux4_scan_ctrl;

  // ---------------- clock / reset / signals ----------------
  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic       stop;
  logic [3:0] dwell;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic [3:0] in_bits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4:1 mux model
  assign mux_out = in_bits[sel];

  mux4_scan_ctrl #(.DWELL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .stop    (stop),
    .dwell   (dwell),
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .sample  (sample)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         chk_en = 0;
  logic [3:0] exp_q[$];
  int         exp_t_q[$];
  logic [3:0] exp_sample = 4'd0;

  // Reference model: a sweep started at edge e0 with dwell d captures channel k
  // at edge e0 + (k+1)*(d+1); the word is visible right after the 4th capture.
  bit         m_scan = 0;
  bit         m_cont = 0;
  bit         m_stop = 0;
  int         m_e0 = 0;
  int         m_d = 0;
  int         m_caps = 0;
  logic [3:0] m_word = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_en = 1;
      m_scan = 0;
      m_caps = 0;
      exp_q.delete();
      exp_t_q.delete();
      exp_sample = 4'd0;
    end else if (!m_scan) begin
      if (start) begin
        m_scan = 1;
        m_e0   = cyc;
        m_d    = int'(dwell);
        m_cont = cont;
        m_stop = 0;
        m_caps = 0;
      end
    end else begin
      if (stop) m_stop = 1;
      if (cyc - m_e0 == (m_caps + 1) * (m_d + 1)) begin
        m_word[m_caps] = in_bits[m_caps];
        m_caps++;
        if (m_caps == 4) begin
          exp_q.push_back(m_word);
          exp_t_q.push_back(cyc);
          if (m_cont && !m_stop) begin
            m_e0   = cyc;
            m_caps = 0;
          end else begin
            m_scan = 0;
            m_caps = 0;
          end
        end
      end
    end
  end

  // Monitor: compare outputs every cycle, pop expected words when done fires.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_done;
      exp_done = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
      chk("busy", 32'(busy), 32'(m_scan));
      chk("sel", 32'(sel), m_scan ? 32'(m_caps) : 32'd0);
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        exp_sample = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end
      chk("sample", 32'(sample), 32'(exp_sample));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [3:0] d, input logic c);
    dwell = d;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!m_scan && exp_t_q.size() == 0) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_sel(input logic [1:0] s, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy && sel == s) return;
    end
    chk("wait_sel_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0;
    dwell = 4'd0; in_bits = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single sweep, one cycle per channel: in0..in3 = 1,0,1,1 -> 4'b1101
    in_bits = 4'b1101;
    pulse_start(4'd0, 1'b0);
    wait_idle(100);

    // dwell 3: in1 glitches high early in its dwell, low again at capture
    in_bits = 4'b0101;
    pulse_start(4'd3, 1'b0);
    wait_sel(2'd1, 100);
    in_bits[1] = 1'b1;
    repeat (2) @(negedge clk);
    in_bits[1] = 1'b0;
    wait_idle(100);

    // continuous, dwell 1: flip in2 after first word, stop mid-sweep later
    in_bits = 4'b0011;
    pulse_start(4'd1, 1'b1);
    wait_done(100);
    in_bits[2] = ~in_bits[2];
    wait_done(100);
    repeat (3) @(negedge clk);
    pulse_stop();
    wait_idle(100);

    // start held high across sweeps
    in_bits = 4'b1010;
    dwell = 4'd2; cont = 1'b0; start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_idle(200);

    // start in the done cycle
    in_bits = 4'b0110;
    pulse_start(4'd1, 1'b0);
    wait_done(100);
    in_bits = 4'b1001;
    pulse_start(4'd2, 1'b0);
    wait_idle(100);

    // reset mid-sweep, then a fresh sweep
    in_bits = 4'b1111;
    pulse_start(4'd3, 1'b0);
    wait_sel(2'd2, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start(4'd3, 1'b0);
    wait_idle(100);

    // maximum dwell
    in_bits = 4'b0111;
    pulse_start(4'd15, 1'b0);
    wait_idle(200);

    // randomized sweeps with input churn, stray starts and stops
    for (int it = 0; it < 12; it++) begin
      logic       c;
      logic [3:0] d;
      int         len;
      c = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 4));
      in_bits = 4'($urandom_range(0, 15));
      pulse_start(d, c);
      len = $urandom_range(5, 60);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) in_bits = 4'($urandom_range(0, 15));
        start = ($urandom_range(0, 7) == 0);
        stop  = (!c && $urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      pulse_stop();
      wait_idle(400);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
